// File: rtl/mw93_cmd_sequencer.sv
// mw93_cmd_sequencer: single-port command engine for a 93xx Microwire EEPROM.
// Serialises start bit, opcode, address and optional data on CS/SK/DI. It
// captures read data from DO and polls ready/busy after WRITE/ERASE.
// Optional build macro: MW_BUSY_TIMEOUT_EN bounds the ready/busy poll to
// BUSY_TIMEOUT clks (BUSY_TIMEOUT must then be at least 2).
module mw93_cmd_sequencer #(
  parameter int ADDR_W       = 6,
  parameter int CLK_DIV      = 4,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ee_cs,
  output logic              ee_sk,
  output logic              ee_di,
  input  logic              ee_do
);

  localparam int H      = 3 + ADDR_W;
  localparam int NMAX   = H + 16;
  localparam int BIT_W  = $clog2(NMAX + 1);
  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int PCNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(BUSY_TIMEOUT - 1);

  localparam logic [2:0] OP_READ  = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_ERASE = 3'd2;
  localparam logic [2:0] OP_EWEN  = 3'd3;
  localparam logic [2:0] OP_EWDS  = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_DESELECT, S_POLL, S_DONE} state_t;

  state_t            state_reg;
  logic [NMAX-1:0]   frame_reg;
  logic [BIT_W-1:0]  bits_left_reg;
  logic [DIV_W-1:0]  div_cnt_reg;
  logic [PCNT_W-1:0] poll_cnt_reg;
  logic [15:0]       rx_shift_reg;
  logic              is_read_reg;
  logic              needs_poll_reg;

  logic [H-1:0]      header_next;
  logic [NMAX-1:0]   frame_next;
  logic [BIT_W-1:0]  nbits_next;
  logic              op_legal;

  assign req_ready = (state_reg == S_IDLE);
  assign op_legal  = (req_op <= OP_EWDS);

  // Build the full outgoing frame and its SK-cycle count for the request on the port
  always_comb begin
    header_next = {1'b1, 2'b00, {ADDR_W{1'b0}}};
    case (req_op)
      OP_READ:  header_next = {1'b1, 2'b10, req_addr};
      OP_WRITE: header_next = {1'b1, 2'b01, req_addr};
      OP_ERASE: header_next = {1'b1, 2'b11, req_addr};
      OP_EWEN:  header_next = {1'b1, 2'b00, 2'b11, {(ADDR_W-2){1'b0}}};
      default:  header_next = {1'b1, 2'b00, {ADDR_W{1'b0}}};
    endcase
    frame_next = {header_next, (req_op == OP_WRITE) ? req_wdata : 16'h0000};
    nbits_next = (req_op == OP_READ || req_op == OP_WRITE) ? BIT_W'(NMAX) : BIT_W'(H);
  end

  // Command engine: accept, SK timing and bit shifting, DO capture, busy poll, response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      frame_reg      <= '0;
      bits_left_reg  <= '0;
      div_cnt_reg    <= '0;
      poll_cnt_reg   <= '0;
      rx_shift_reg   <= '0;
      is_read_reg    <= 1'b0;
      needs_poll_reg <= 1'b0;
      ee_cs          <= 1'b0;
      ee_sk          <= 1'b0;
      ee_di          <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_err        <= 1'b0;
      rsp_rdata      <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            if (!op_legal) begin
              // illegal op: no bus activity, rdata left untouched
              state_reg <= S_DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state_reg      <= S_SHIFT;
              ee_cs          <= 1'b1;
              ee_sk          <= 1'b0;
              ee_di          <= frame_next[NMAX-1];
              frame_reg      <= frame_next;
              bits_left_reg  <= nbits_next;
              div_cnt_reg    <= '0;
              is_read_reg    <= (req_op == OP_READ);
              needs_poll_reg <= (req_op == OP_WRITE || req_op == OP_ERASE);
              rsp_rdata      <= '0;
            end
          end
        end
        S_SHIFT: begin
          if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
            if (!ee_sk) begin
              // rising SK: capture DO; the last 16 captures are the read word
              ee_sk        <= 1'b1;
              rx_shift_reg <= {rx_shift_reg[14:0], ee_do};
            end else begin
              ee_sk <= 1'b0;
              if (bits_left_reg == BIT_W'(1)) begin
                state_reg <= S_DESELECT;
                ee_cs     <= 1'b0;
                ee_di     <= 1'b0;
              end else begin
                bits_left_reg <= bits_left_reg - 1'b1;
                frame_reg     <= {frame_reg[NMAX-2:0], 1'b0};
                ee_di         <= frame_reg[NMAX-2];
              end
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        S_DESELECT: begin
          if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
            if (needs_poll_reg) begin
              state_reg    <= S_POLL;
              ee_cs        <= 1'b1;
              poll_cnt_reg <= '0;
            end else begin
              state_reg <= S_DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              if (is_read_reg) rsp_rdata <= rx_shift_reg;
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        S_POLL: begin
          // DO on the first poll clk may still reflect the bus turnaround; ignore it
          if (poll_cnt_reg != '0 && ee_do) begin
            state_reg <= S_DONE;
            ee_cs     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
          end
`ifdef MW_BUSY_TIMEOUT_EN
          else if (poll_cnt_reg == PCNT_LAST) begin
            state_reg <= S_DONE;
            ee_cs     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end
`endif
          if (poll_cnt_reg != PCNT_LAST) poll_cnt_reg <= poll_cnt_reg + 1'b1;
        end
        S_DONE: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mw93_cmd_sequencer.sv
// tb_mw93_cmd_sequencer: randomized bench with a cycle-schedule reference model.
// At every accept the model expands the command into the expected per-cycle
// bus/response values (plus the DO level the EEPROM model drives) and a
// single compare process checks the DUT against that schedule every clk.
module tb_mw93_cmd_sequencer;

  localparam int ADDR_W       = 6;
  localparam int CLK_DIV      = 2;
  localparam int BUSY_TIMEOUT = 100;
  localparam int H            = 3 + ADDR_W;
  localparam int LAT_LIMIT    = 20000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [2:0]        req_op = 3'd0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [15:0]       req_wdata = 16'h0;
  logic              rsp_valid;
  logic [15:0]       rsp_rdata;
  logic              rsp_err;
  logic              ee_cs, ee_sk, ee_di;
  logic              ee_do = 1'b0;

  mw93_cmd_sequencer #(.ADDR_W(ADDR_W), .CLK_DIV(CLK_DIV), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ee_cs(ee_cs), .ee_sk(ee_sk), .ee_di(ee_di), .ee_do(ee_do)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_drv;
    logic        cs, sk, di, valid, err, ready;
    logic [15:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] model_rdata = 16'h0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic d, input logic cs, input logic sk, input logic di,
                              input logic v, input logic e, input logic rdy, input logic [15:0] rd);
    exp_t x;
    x.do_drv = d; x.cs = cs; x.sk = sk; x.di = di;
    x.valid = v; x.err = e; x.ready = rdy; x.rdata = rd;
    return x;
  endfunction

  // Header bits (start, opcode, address field), MSB first
  function automatic logic [H-1:0] header(input int op, input int addr);
    logic [ADDR_W-1:0] a;
    a = addr[ADDR_W-1:0];
    case (op)
      0:       return {1'b1, 2'b10, a};
      1:       return {1'b1, 2'b01, a};
      2:       return {1'b1, 2'b11, a};
      3:       return {1'b1, 2'b00, 2'b11, {(ADDR_W-2){1'b0}}};
      default: return {1'b1, 2'b00, {ADDR_W{1'b0}}};
    endcase
  endfunction

  // Expand one accepted command into its expected cycle-by-cycle schedule
  task automatic push_schedule(input int op, input int addr, input logic [15:0] wdata,
                               input logic [15:0] rd, input int busy);
    logic [H-1:0] hdr;
    int n, kready, len;
    logic b, dd, err;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, model_rdata));
    if (op > 4) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, model_rdata));
      return;
    end
    hdr = header(op, addr);
    n = (op <= 1) ? H + 16 : H;
    for (int j = 0; j < n; j++) begin
      if (j < H) b = hdr[H-1-j];
      else       b = (op == 1) ? wdata[15-(j-H)] : 1'b0;
      dd = (op == 0 && j >= H) ? rd[15-(j-H)] : 1'b0;
      for (int k = 0; k < 2*CLK_DIV; k++)
        exp_q.push_back(mk(dd, 1'b1, (k >= CLK_DIV), b, 1'b0, 1'b0, 1'b0, 16'h0));
    end
    for (int k = 0; k < CLK_DIV; k++)
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0));
    err = 1'b0;
    if (op == 1 || op == 2) begin
      kready = (busy < 1) ? 1 : busy;
      len = kready + 1;
`ifdef MW_BUSY_TIMEOUT_EN
      if (kready > BUSY_TIMEOUT - 1) begin
        len = BUSY_TIMEOUT;
        err = 1'b1;
      end
`endif
      for (int i = 0; i < len; i++)
        exp_q.push_back(mk((i >= busy), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0));
    end
    model_rdata = (op == 0) ? rd : 16'h0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, err, 1'b0, model_rdata));
  endtask

  // Compare process: one check set per clk, sampled mid-cycle; also plays the EEPROM DO pin
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        ee_do = 1'b0;
        check("rst_cs", {15'd0, ee_cs}, 16'd0);
        check("rst_sk", {15'd0, ee_sk}, 16'd0);
        check("rst_di", {15'd0, ee_di}, 16'd0);
        check("rst_valid", {15'd0, rsp_valid}, 16'd0);
        check("rst_rdata", rsp_rdata, 16'h0);
      end else begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, model_rdata);
        ee_do = e.do_drv;
        check("cs", {15'd0, ee_cs}, {15'd0, e.cs});
        check("sk", {15'd0, ee_sk}, {15'd0, e.sk});
        check("di", {15'd0, ee_di}, {15'd0, e.di});
        check("rsp_valid", {15'd0, rsp_valid}, {15'd0, e.valid});
        check("req_ready", {15'd0, req_ready}, {15'd0, e.ready});
        check("rsp_rdata", rsp_rdata, e.rdata);
        if (e.valid) check("rsp_err", {15'd0, rsp_err}, {15'd0, e.err});
      end
    end
  end

  // Present a request in the current idle cycle; returns one cycle after the accept
  task automatic start_cmd(input int op, input int addr, input logic [15:0] wdata,
                           input logic [15:0] rd, input int busy);
    req_valid = 1'b1;
    req_op    = op[2:0];
    req_addr  = addr[ADDR_W-1:0];
    req_wdata = wdata;
    push_schedule(op, addr, wdata, rd, busy);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    req_addr  = ADDR_W'($urandom);
    req_wdata = 16'($urandom);
  endtask

  // Wait for the response pulse (bounded); optionally hold req_valid during DONE
  task automatic finish_cmd(input bit hold, output int lat, output logic [15:0] rdata, output logic err);
    lat = 1;
    while (!rsp_valid) begin
      if (lat >= LAT_LIMIT) begin
        fails++;
        $display("FAIL rsp_timeout at %0t: got no rsp_valid after %0d clks expected a response", $time, lat);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
      @(posedge clk); #1;
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    if (hold) begin
      req_valid = 1'b1;
      req_op    = 3'($urandom_range(0, 4));
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    int lat;
    logic [15:0] rdata;
    logic err;
    int op, busy;

    // model pins
    check("hdr_read15", {7'd0, header(0, 'h15)}, 16'b110010101);
    check("hdr_ewen",   {7'd0, header(3, 'h2A)}, 16'b100110000);
    check("hdr_ewds",   {7'd0, header(4, 'h3F)}, 16'b100000000);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // READ 0x15 -> 0xA5C3
    start_cmd(0, 'h15, 16'h0, 16'hA5C3, 0);
    finish_cmd(1'b0, lat, rdata, err);
    check("read_latency", 16'(lat), 16'd103);
    check("read_data", rdata, 16'hA5C3);
    check("read_err", {15'd0, err}, 16'd0);

    // illegal op keeps prior read data
    start_cmd(6, 'h3, 16'h0, 16'h0, 0);
    finish_cmd(1'b0, lat, rdata, err);
    check("illegal_latency", 16'(lat), 16'd1);
    check("illegal_err", {15'd0, err}, 16'd1);
    check("illegal_rdata", rdata, 16'hA5C3);

    // EWEN then WRITE 0x3F <- 0x1234 with 40 clks busy
    start_cmd(3, 'h0, 16'h0, 16'h0, 0);
    finish_cmd(1'b0, lat, rdata, err);
    check("ewen_latency", 16'(lat), 16'd39);
    start_cmd(1, 'h3F, 16'h1234, 16'h0, 40);
    finish_cmd(1'b0, lat, rdata, err);
    check("write_latency", 16'(lat), 16'd144);
    check("write_err", {15'd0, err}, 16'd0);
    check("write_rdata", rdata, 16'h0);

    // async reset during WRITE data bit 5
    start_cmd(1, 'h11, 16'hBEEF, 16'h0, 10);
    repeat (2*CLK_DIV*(H+5)) @(posedge clk);
    #1;
    check("pre_rst_cs", {15'd0, ee_cs}, 16'd1);
    rst = 1'b1;
    exp_q.delete();
    model_rdata = 16'h0;
    #1;
    check("async_rst_cs", {15'd0, ee_cs}, 16'd0);
    check("async_rst_sk", {15'd0, ee_sk}, 16'd0);
    check("async_rst_di", {15'd0, ee_di}, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", {15'd0, req_ready}, 16'd1);
    start_cmd(0, 'h2C, 16'h0, 16'h5A0F, 0);
    finish_cmd(1'b0, lat, rdata, err);
    check("post_rst_read", rdata, 16'h5A0F);

`ifdef MW_BUSY_TIMEOUT_EN
    // ERASE with DO stuck low must time out
    start_cmd(2, 'h07, 16'h0, 16'h0, 1000000);
    finish_cmd(1'b0, lat, rdata, err);
    check("timeout_err", {15'd0, err}, 16'd1);
`endif

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      op   = (($urandom_range(0, 9)) < 8) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
      busy = int'($urandom_range(0, 40));
      start_cmd(op, int'($urandom_range(0, (1 << ADDR_W) - 1)), 16'($urandom), 16'($urandom), busy);
      finish_cmd(bit'($urandom_range(0, 1)), lat, rdata, err);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
